ram_word_fetcher: RTL

RAM_WORD_FETCHER -- requirements
Module: ram_word_fetcher

---
 rtl/hash_gen_pkg.sv | 33 +++
 rtl/line_serializer.sv | 50 +++++
 rtl/ram_word_fetcher.sv | 105 ++++++++++
 3 files changed

// File: rtl/hash_gen_pkg.sv
// Shared definitions for the hash-input fetch path: line/word geometry,
// fetch FSM encoding and the MSB-first word selection helper.
package hash_gen_pkg;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int IDX_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
    } fetch_state_e;

    // Word 0 is the most significant slice of the line.
    function automatic logic [WORD_W-1:0] select_word(
        input logic [LINE_W-1:0] line,
        input logic [IDX_W-1:0]  idx
    );
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = line[127:96];
            2'd1:    w = line[95:64];
            2'd2:    w = line[63:32];
            2'd3:    w = line[31:0];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/line_serializer.sv
// Holds one memory line and presents it as a sequence of 32-bit words,
// stepping to the next word only when the consumer accepts the current one.
module line_serializer
    import hash_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [LINE_W-1:0] data_i,
    output logic [WORD_W-1:0] word_out_o,
    output logic [IDX_W-1:0]  index_o
);

    logic [LINE_W-1:0] line_q, line_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;

    // Next-state for buffer and word index; word_out is pre-selected so it is a flop output.
    always_comb begin
        line_d = line_q;
        idx_d  = idx_q;
        if (load_i) begin
            line_d = data_i;
            idx_d  = 2'd0;
        end else if (advance_i) begin
            idx_d  = idx_q + 2'd1;
        end else begin
            idx_d  = idx_q;
        end
        word_d = select_word(line_d, idx_d);
    end

    // Buffer, index and word registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            line_q <= 128'h0;
            idx_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            line_q <= line_d;
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_out_o = word_q;
    assign index_o    = idx_q;

endmodule

// File: rtl/ram_word_fetcher.sv
// Fetches NUM_ENTRIES 128-bit lines from the input memory and streams each
// line to the hash core as four 32-bit words over a valid/ready handshake.
module ram_word_fetcher
    import hash_gen_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    output logic              next,
    input  logic [LINE_W-1:0] data_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic [7:0]        line_idx
);

    localparam logic [7:0] LAST_LINE = 8'(NUM_ENTRIES - 1);

    fetch_state_e state_q, state_d;
    logic [7:0]   line_q, line_d;
    logic         load_s;
    logic         advance_s;
    logic [IDX_W-1:0] word_idx_s;

    // Fetch sequencing: request, capture, then drain four words per line.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        load_s    = 1'b0;
        advance_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_REQ;
                    line_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_REQ: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                load_s  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (word_ready) begin
                    advance_s = 1'b1;
                    if (word_idx_s == 2'd3) begin
                        if (line_q == LAST_LINE) begin
                            state_d = ST_DONE;
                        end else begin
                            line_d  = line_q + 8'd1;
                            state_d = ST_REQ;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = 8'd0;
            end
        endcase
    end

    // State and line counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            line_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
        end
    end

    line_serializer u_ser (
        .clk        (clk),
        .reset_L    (reset_L),
        .load_i     (load_s),
        .advance_i  (advance_s),
        .data_i     (data_in),
        .word_out_o (word_out),
        .index_o    (word_idx_s)
    );

    // Moore outputs decoded from registered state only.
    assign next       = (state_q == ST_REQ);
    assign word_valid = (state_q == ST_SEND);
    assign word_last  = (state_q == ST_SEND) && (word_idx_s == 2'd3) && (line_q == LAST_LINE);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign line_idx   = line_q;

endmodule
